mem_arbiter: RTL and testbench

- Two-requester arbiter and sequencer for the single-port unified instruction/data memory of the multicycle ARM core.
- Port 0 is the core (Adr/WriteData/MemWrite path); port 1 is a loader/DMA requester used to preload or inspect memory.
- Serialises accesses, applies the memory's fixed read latency, and returns a one-cycle ready pulse with read data to the granted requester.
- Sits inside top, between arm and mem.

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port round-robin arbiter/sequencer for the unified memory
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-low reset
//   req0/we0/adr0/wd0   core request, write enable, byte address, write data
//   rdy0                one-cycle completion pulse to the core
//   req1/we1/adr1/wd1   loader/DMA request port, same meanings
//   rdy1                one-cycle completion pulse to the loader
//   rdata               data of the most recent completed read
//   gnt                 index of the port currently or most recently granted
//   mem_adr/mem_wd      memory address / write data (zero outside an access)
//   mem_we              memory write strobe (first access cycle of a write only)
//   mem_rd              memory read data, valid MEM_LAT cycles after mem_adr
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] adr0,
    input  logic [DW-1:0] wd0,
    output logic          rdy0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] adr1,
    input  logic [DW-1:0] wd1,
    output logic          rdy1,
    output logic [DW-1:0] rdata,
    output logic          gnt,
    output logic [AW-1:0] mem_adr,
    output logic [DW-1:0] mem_wd,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

    state_t        state;
    logic [3:0]    cnt;
    logic          lat_we;
    logic [AW-1:0] lat_adr;
    logic [DW-1:0] lat_wd;
    logic          pick;

    // Port chosen if a grant happens this cycle; on a tie the port that was
    // not granted last time wins, so continuous contention alternates.
    always_comb begin
        pick = gnt;
        if (req0 && req1) begin
            pick = ~gnt;
        end else if (req0) begin
            pick = 1'b0;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            lat_we  <= 1'b0;
            lat_adr <= '0;
            lat_wd  <= '0;
            rdy0    <= 1'b0;
            rdy1    <= 1'b0;
            rdata   <= '0;
            gnt     <= 1'b1;
            mem_adr <= '0;
            mem_wd  <= '0;
            mem_we  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rdy0 <= 1'b0;
                    rdy1 <= 1'b0;
                    if (req0 || req1) begin
                        gnt     <= pick;
                        lat_we  <= pick ? we1  : we0;
                        lat_adr <= pick ? adr1 : adr0;
                        lat_wd  <= pick ? wd1  : wd0;
                        // Outputs are registered, so load them now to have
                        // them valid during the first ACCESS cycle.
                        mem_adr <= pick ? adr1 : adr0;
                        mem_wd  <= pick ? wd1  : wd0;
                        mem_we  <= pick ? we1  : we0;
                        cnt     <= 4'd0;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_we <= 1'b0;
                    cnt    <= cnt + 4'd1;
                    if (cnt == LAST) begin
                        if (!lat_we) begin
                            rdata <= mem_rd;
                        end
                        mem_adr <= '0;
                        mem_wd  <= '0;
                        rdy0    <= ~gnt;
                        rdy1    <= gnt;
                        state   <= DONE;
                    end else begin
                        mem_adr <= lat_adr;
                        mem_wd  <= lat_wd;
                    end
                end
                DONE: begin
                    rdy0  <= 1'b0;
                    rdy1  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    rdy0    <= 1'b0;
                    rdy1    <= 1'b0;
                    mem_we  <= 1'b0;
                    mem_adr <= '0;
                    mem_wd  <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        clk;
    logic        reset;

    // instance a: MEM_LAT=1 with a combinational-read memory model
    logic        req0, we0, req1, we1;
    logic [31:0] adr0, wd0, adr1, wd1;
    logic        rdy0, rdy1, gnt, mem_we;
    logic [31:0] rdata, mem_adr, mem_wd, mem_rd;

    // instance b: MEM_LAT=3, read data driven directly by the bench
    logic        b_req0, b_we0, b_req1, b_we1;
    logic [31:0] b_adr0, b_wd0, b_adr1, b_wd1;
    logic        b_rdy0, b_rdy1, b_gnt, b_mem_we;
    logic [31:0] b_rdata, b_mem_adr, b_mem_wd, b_mem_rd;

    logic [31:0] mem [0:63];

    int checks = 0;
    int failures = 0;

    int t_lat, t_nwe, t_adrcyc, t_other;
    logic [31:0] t_we_adr, t_we_wd;

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(1)) u_a (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .adr0(adr0), .wd0(wd0), .rdy0(rdy0),
        .req1(req1), .we1(we1), .adr1(adr1), .wd1(wd1), .rdy1(rdy1),
        .rdata(rdata), .gnt(gnt),
        .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
    );

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3)) u_b (
        .clk(clk), .reset(reset),
        .req0(b_req0), .we0(b_we0), .adr0(b_adr0), .wd0(b_wd0), .rdy0(b_rdy0),
        .req1(b_req1), .we1(b_we1), .adr1(b_adr1), .wd1(b_wd1), .rdy1(b_rdy1),
        .rdata(b_rdata), .gnt(b_gnt),
        .mem_adr(b_mem_adr), .mem_wd(b_mem_wd), .mem_we(b_mem_we), .mem_rd(b_mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we === 1'b1) mem[mem_adr[7:2]] <= mem_wd;
    end
    assign mem_rd = mem[mem_adr[7:2]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One transaction on instance a; waits for the next cycle, raises req,
    // then watches up to 10 cycles for the rdy pulse of that port.
    task automatic run_txn(input bit p, input bit we, input logic [31:0] adr,
                           input logic [31:0] wd);
        @(negedge clk);
        t_lat = -1; t_nwe = 0; t_adrcyc = 0; t_other = 0;
        t_we_adr = '0; t_we_wd = '0;
        if (p) begin req1 = 1; we1 = we; adr1 = adr; wd1 = wd; end
        else   begin req0 = 1; we0 = we; adr0 = adr; wd0 = wd; end
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (mem_we !== 1'b0) begin
                t_nwe++; t_we_adr = mem_adr; t_we_wd = mem_wd;
            end
            if (mem_adr === adr) t_adrcyc++;
            if ((p ? rdy0 : rdy1) !== 1'b0) t_other++;
            if ((p ? rdy1 : rdy0) === 1'b1) begin
                t_lat = i;
                req0 = 0; req1 = 0;
                break;
            end
        end
        req0 = 0; req1 = 0;
    endtask

    initial begin
        int order [0:5];
        int k, both, bad;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[6'h18] = 32'h0000_0007;   // 0x60
        mem[6'h1a] = 32'h0000_0055;   // 0x68
        reset = 0;
        req0 = 0; we0 = 0; adr0 = 0; wd0 = 0;
        req1 = 0; we1 = 0; adr1 = 0; wd1 = 0;
        b_req0 = 0; b_we0 = 0; b_adr0 = 0; b_wd0 = 0;
        b_req1 = 0; b_we1 = 0; b_adr1 = 0; b_wd1 = 0;
        b_mem_rd = 32'hdead_beef;

        // reset state
        #12;
        check("rst_gnt", 32'(gnt), 32'd1);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_adr", mem_adr, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_rdy", {30'd0, rdy1, rdy0}, 32'd0);
        #10 reset = 1;

        // core read of 0x60
        run_txn(0, 0, 32'h60, 32'h0);
        check("rd_lat", 32'(t_lat), 32'd2);
        check("rd_adr_cycles", 32'(t_adrcyc), 32'd1);
        check("rd_no_we", 32'(t_nwe), 32'd0);
        check("rd_rdy1_quiet", 32'(t_other), 32'd0);
        check("rd_rdata", rdata, 32'h7);
        @(negedge clk);
        check("rd_rdy0_once", 32'(rdy0), 32'd0);

        // read 0x68, then write 0x64 must leave rdata at 0x55
        run_txn(0, 0, 32'h68, 32'h0);
        check("rd2_rdata", rdata, 32'h55);
        run_txn(0, 1, 32'h64, 32'h7);
        check("wr_lat", 32'(t_lat), 32'd2);
        check("wr_we_cycles", 32'(t_nwe), 32'd1);
        check("wr_we_adr", t_we_adr, 32'h64);
        check("wr_we_wd", t_we_wd, 32'h7);
        check("wr_rdata_kept", rdata, 32'h55);
        run_txn(0, 0, 32'h64, 32'h0);
        check("wr_readback", rdata, 32'h7);

        // contention from reset: grants must alternate 0,1,0,1,0,1
        @(negedge clk); reset = 0;
        @(negedge clk); reset = 1;
        req0 = 1; we0 = 0; adr0 = 32'h60;
        req1 = 1; we1 = 0; adr1 = 32'h68;
        k = 0; both = 0;
        for (int i = 0; i < 60 && k < 6; i++) begin
            @(negedge clk);
            if (rdy0 === 1'b1 && rdy1 === 1'b1) both++;
            else if (rdy0 === 1'b1 || rdy1 === 1'b1) begin
                order[k] = rdy1 ? 1 : 0;
                check("rr_gnt_match", 32'(gnt), 32'(order[k]));
                k++;
            end
        end
        req0 = 0; req1 = 0;
        check("rr_count", 32'(k), 32'd6);
        check("rr_both_rdy", 32'(both), 32'd0);
        for (int i = 0; i < k; i++) check("rr_order", 32'(order[i]), 32'(i % 2));

        // MEM_LAT=3 on instance b
        @(negedge clk);
        b_req0 = 1; b_we0 = 0; b_adr0 = 32'h10;
        k = -1; bad = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) b_adr0 = 32'h20;   // must not disturb the access
            if (i <= 3 && b_mem_adr !== 32'h10) bad++;
            b_mem_rd = (i == 3) ? 32'h1234_abcd : 32'hdead_beef;
            if (b_rdy0 === 1'b1) begin
                k = i; b_req0 = 0; break;
            end
        end
        b_req0 = 0;
        check("lat3_rdy", 32'(k), 32'd4);
        check("lat3_adr_held", 32'(bad), 32'd0);
        check("lat3_rdata", b_rdata, 32'h1234_abcd);

        // reset during the first ACCESS cycle of a write
        @(negedge clk);
        req0 = 1; we0 = 1; adr0 = 32'h70; wd0 = 32'h99;
        @(negedge clk);
        check("rst_mid_we_before", 32'(mem_we), 32'd1);
        #1 reset = 0;
        #1;
        check("rst_mid_we", 32'(mem_we), 32'd0);
        check("rst_mid_rdy", {30'd0, rdy1, rdy0}, 32'd0);
        req0 = 0; we0 = 0;
        @(negedge clk); reset = 1;
        @(negedge clk);
        check("rst_mid_gnt", 32'(gnt), 32'd1);
        check("rst_mid_adr", mem_adr, 32'h0);
        check("rst_mid_rdy_after", {30'd0, rdy1, rdy0}, 32'd0);
        run_txn(0, 0, 32'h60, 32'h0);
        check("rst_mid_next_lat", 32'(t_lat), 32'd2);
        check("rst_mid_next_rdata", rdata, 32'h7);

        // idle stability
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_we !== 1'b0 || mem_adr !== 32'h0 || rdy0 !== 1'b0 || rdy1 !== 1'b0) bad++;
            if ($isunknown({rdata, gnt, mem_wd, b_mem_we, b_rdy0, b_rdy1, b_mem_adr})) bad++;
        end
        check("idle_stable", 32'(bad), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
